// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron datapath blocks.
//   - Activation mode encodings (act_mode input).
//   - Controller state encodings (2-bit legacy-compatible constants).
//   - Saturation helpers that operate on a 64-bit signed working value and
//     clamp to a run-time supplied output width.
// -----------------------------------------------------------------------------
package nn_pkg;

    // Activation mode encodings; 2'd3 behaves as identity.
    localparam logic [1:0] ACT_IDENT = 2'd0;
    localparam logic [1:0] ACT_RELU  = 2'd1;
    localparam logic [1:0] ACT_LEAKY = 2'd2;

    // Controller states
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Width of the signed working value used by the clamp helpers.
    // Accumulator widths must not exceed this.
    localparam int SAT_W = 64;

    // Clamp v to the signed range of an ow-bit integer.
    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input logic signed [SAT_W-1:0] v,
        input int                      ow
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // High when v lies outside the signed range of an ow-bit integer.
    function automatic logic sat_hit(
        input logic signed [SAT_W-1:0] v,
        input int                      ow
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// -----------------------------------------------------------------------------
// neuron_act_sat
// Combinational post-processing of the biased accumulator:
//   fixed-point rescale (arithmetic >>> FRAC_BITS), activation, then clamp to
//   the OUT_WIDTH signed range.
// Optional: NEURON_SAT_FLAG_EN adds sat_o, high when the activated value had
//   to be clamped at either rail.
// Ports:
//   sum_i   in  ACC_WIDTH  biased accumulator (Q with 2*FRAC_BITS fraction)
//   mode_i  in  2          activation mode (nn_pkg ACT_* encodings)
//   res_o   out OUT_WIDTH  activated, saturated result
//   sat_o   out 1          clamp indicator (NEURON_SAT_FLAG_EN only)
// -----------------------------------------------------------------------------
module neuron_act_sat
    import nn_pkg::*;
#(
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic [ACC_WIDTH-1:0] sum_i,
    input  logic [1:0]           mode_i,
    output logic [OUT_WIDTH-1:0] res_o
`ifdef NEURON_SAT_FLAG_EN
    ,
    output logic                 sat_o
`endif
);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] act_val;

    assign shifted = $signed(sum_i) >>> FRAC_BITS;

    always_comb begin
        act_val = shifted;
        if (shifted[ACC_WIDTH-1]) begin
            if (mode_i == ACT_RELU) begin
                act_val = '0;
            end else if (mode_i == ACT_LEAKY) begin
                // arithmetic shift floors, i.e. rounds toward -inf
                act_val = shifted >>> 3;
            end
        end
    end

    assign res_o = OUT_WIDTH'(sat_clamp(SAT_W'(act_val), OUT_WIDTH));

`ifdef NEURON_SAT_FLAG_EN
    assign sat_o = sat_hit(SAT_W'(act_val), OUT_WIDTH);
`endif

endmodule

// File: rtl/neuron_mac_pipe.sv
// -----------------------------------------------------------------------------
// neuron_mac_pipe
// Multi-lane neuron: LANES data/weight products per beat, two-stage
// multiply / adder-tree accumulate, fixed-point bias add, selectable
// activation and saturation, ready/valid output with backpressure.
// Optional: NEURON_SAT_FLAG_EN adds the sat_flag output.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   data_in    LANES*IN_WIDTH packed data lanes (lane 0 in LSBs)
//   weight_in  LANES*IN_WIDTH packed weight lanes (lane 0 in LSBs)
//   bias_in    bias, latched on the last-beat accept
//   act_mode   activation mode, latched on the last-beat accept
//   in_valid / in_ready    beat handshake
//   data_out / out_valid / out_ready  result handshake
//   sat_flag   result was clamped (NEURON_SAT_FLAG_EN only)
// Flow: ACCUM (beats) -> DRAIN (last products land) -> FINAL (bias,
// activation, register result) -> OUT (hold until out_ready).
// -----------------------------------------------------------------------------
module neuron_mac_pipe
    import nn_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int NUM_INPUTS = 784,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*IN_WIDTH-1:0] data_in,
    input  logic [LANES*IN_WIDTH-1:0] weight_in,
    input  logic [IN_WIDTH-1:0]       bias_in,
    input  logic [1:0]                act_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_WIDTH-1:0]      data_out,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef NEURON_SAT_FLAG_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam int NUM_BEATS = NUM_INPUTS / LANES;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PROD_W    = 2 * IN_WIDTH;

    generate
        if (NUM_INPUTS % LANES != 0) begin : g_bad_lanes
            $error("neuron_mac_pipe: NUM_INPUTS must be a multiple of LANES");
        end
        if (ACC_WIDTH < 2 * IN_WIDTH + $clog2(NUM_INPUTS)) begin : g_bad_acc
            $error("neuron_mac_pipe: ACC_WIDTH too small for NUM_INPUTS products");
        end
        if (ACC_WIDTH > SAT_W) begin : g_bad_acc_max
            $error("neuron_mac_pipe: ACC_WIDTH exceeds saturation working width");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             accept;
    logic             last_beat;

    assign in_ready  = (state_q == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));

    // ---------------- stage 1: lane products ----------------
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     s1_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod_d[gi] = $signed(data_in[gi*IN_WIDTH +: IN_WIDTH])
                              * $signed(weight_in[gi*IN_WIDTH +: IN_WIDTH]);

            always_ff @(posedge clk) begin
                if (accept) begin
                    prod_q[gi] <= prod_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
    end

    // ---------------- stage 2: adder tree + accumulate ----------------
    // Summing directly at ACC_WIDTH: the width check above guarantees the
    // lane sum cannot overflow it.
    logic signed [ACC_WIDTH-1:0] tree_sum;
    logic signed [ACC_WIDTH-1:0] acc_q;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + ACC_WIDTH'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == ST_FINAL) begin
            acc_q <= '0;
        end else if (s1_valid_q) begin
            acc_q <= acc_q + tree_sum;
        end
    end

    // ---------------- per-neuron latched controls ----------------
    logic signed [IN_WIDTH-1:0] bias_q;
    logic [1:0]                 mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q <= '0;
            mode_q <= ACT_IDENT;
        end else if (accept && last_beat) begin
            bias_q <= $signed(bias_in);
            mode_q <= act_mode;
        end
    end

    // ---------------- FINAL: bias, activation, saturation ----------------
    // The accumulator carries 2*FRAC_BITS fractional bits, so the bias is
    // aligned by FRAC_BITS before adding.
    logic signed [ACC_WIDTH-1:0] final_sum;
    logic [OUT_WIDTH-1:0]        act_res;

    assign final_sum = acc_q + (ACC_WIDTH'(bias_q) <<< FRAC_BITS);

`ifdef NEURON_SAT_FLAG_EN
    logic act_sat;
`endif

    neuron_act_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_act_sat (
        .sum_i  (final_sum),
        .mode_i (mode_q),
        .res_o  (act_res)
`ifdef NEURON_SAT_FLAG_EN
        ,
        .sat_o  (act_sat)
`endif
    );

    // ---------------- controller ----------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: state_d = ST_FINAL;
            ST_FINAL: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ---------------- output registers ----------------
    logic [OUT_WIDTH-1:0] data_out_q;
    logic                 out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (state_q == ST_FINAL) begin
            data_out_q  <= act_res;
            out_valid_q <= 1'b1;
        end else if (state_q == ST_OUT && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

`ifdef NEURON_SAT_FLAG_EN
    logic sat_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else if (state_q == ST_FINAL) begin
            sat_flag_q <= act_sat;
        end
    end

    assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_pipe
// Directed bench for neuron_mac_pipe with LANES=4, NUM_INPUTS=8 (two beats),
// Q8.8 16-bit data. Every lane of a neuron carries the same data/weight pair,
// so expected results are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_neuron_mac_pipe;

    localparam int IW  = 16;
    localparam int LN  = 4;
    localparam int NI  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [LN*IW-1:0] data_in;
    logic [LN*IW-1:0] weight_in;
    logic [IW-1:0]   bias_in;
    logic [1:0]      act_mode;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     data_out;
    logic            out_valid;
    logic            out_ready;
`ifdef NEURON_SAT_FLAG_EN
    logic            sat_flag;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    neuron_mac_pipe #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (16),
        .FRAC_BITS  (8),
        .LANES      (LN),
        .NUM_INPUTS (NI),
        .ACC_WIDTH  (48)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .weight_in (weight_in),
        .bias_in   (bias_in),
        .act_mode  (act_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NEURON_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send both beats of one neuron. Returns #1 after the last accept edge.
    task automatic send_neuron(input logic [15:0] d, input logic [15:0] w,
                               input logic [15:0] b, input logic [1:0] m,
                               input bit gaps);
        for (int beat = 0; beat < NI / LN; beat++) begin
            int guard;
            if (gaps) begin
                in_valid = 1'b0;
                step();
            end
            data_in   = {LN{d}};
            weight_in = {LN{w}};
            bias_in   = b;
            act_mode  = m;
            in_valid  = 1'b1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                step();
                guard++;
            end
            if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, let out_ready consume it.
    task automatic get_result(input string tag, input logic [15:0] exp);
        int guard = 0;
        while (!out_valid && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check({tag, "_timeout"}, 32'd0, 32'd1);
        else check(tag, {16'd0, data_out}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] held;
        rst       = 1'b1;
        data_in   = '0;
        weight_in = '0;
        bias_in   = '0;
        act_mode  = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        rst = 1'b0;
        step();

        // ---- latency: 1.0*1.0*8 = 8.0 -> 0x0800 in the 3rd cycle after accept
        send_neuron(16'h0100, 16'h0100, 16'h0000, 2'd1, 1'b0);
        check("lat_valid_c1", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid_c2", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid_c3", {31'd0, out_valid}, 32'd1);
        check("lat_data", {16'd0, data_out}, 32'h0800);
        check("lat_in_ready_busy", {31'd0, in_ready}, 32'd0);
        step();
        check("lat_valid_drop", {31'd0, out_valid}, 32'd0);
        check("lat_in_ready_back", {31'd0, in_ready}, 32'd1);

        // ---- activations: -8.0 + 0.5 = -7.5
        send_neuron(16'h0100, 16'hFF00, 16'h0080, 2'd0, 1'b0);
        get_result("ident_neg", 16'hF880);
        step();
        send_neuron(16'h0100, 16'hFF00, 16'h0080, 2'd1, 1'b0);
        get_result("relu_neg", 16'h0000);
`ifdef NEURON_SAT_FLAG_EN
        check("relu_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif
        step();
        send_neuron(16'h0100, 16'hFF00, 16'h0080, 2'd2, 1'b0);
        get_result("leaky_neg", 16'hFF10);
        step();
        send_neuron(16'h0100, 16'h0100, 16'h0000, 2'd3, 1'b0);
        get_result("mode3_ident", 16'h0800);
        step();

        // ---- saturation at both rails
        send_neuron(16'h7FFF, 16'h7FFF, 16'h0000, 2'd0, 1'b0);
        get_result("sat_pos", 16'h7FFF);
`ifdef NEURON_SAT_FLAG_EN
        check("sat_pos_flag", {31'd0, sat_flag}, 32'd1);
`endif
        step();
        send_neuron(16'h7FFF, 16'h8000, 16'h0000, 2'd0, 1'b0);
        get_result("sat_neg", 16'h8000);
`ifdef NEURON_SAT_FLAG_EN
        check("sat_neg_flag", {31'd0, sat_flag}, 32'd1);
`endif
        step();

        // ---- backpressure: hold result 5 cycles while next beats wait
        out_ready = 1'b0;
        send_neuron(16'h0100, 16'h0100, 16'h0000, 2'd1, 1'b0);
        get_result("bp_first", 16'h0800);
        held = data_out;
        data_in   = {LN{16'h0100}};
        weight_in = {LN{16'hFF00}};
        bias_in   = 16'h0080;
        act_mode  = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold_data_%0d", i), {16'd0, data_out}, {16'd0, held});
            check($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release", {31'd0, out_valid}, 32'd0);
        send_neuron(16'h0100, 16'hFF00, 16'h0080, 2'd0, 1'b0);
        get_result("bp_next", 16'hF880);
        step();

        // ---- in_valid toggling gives identical results
        send_neuron(16'h0100, 16'hFF00, 16'h0080, 2'd2, 1'b1);
        get_result("gap_leaky", 16'hFF10);
        step();
        send_neuron(16'h0100, 16'h0100, 16'h0000, 2'd1, 1'b1);
        get_result("gap_relu", 16'h0800);
        step();

        // ---- reset after beat 0 discards the partial sum
        data_in   = {LN{16'h0100}};
        weight_in = {LN{16'h0100}};
        bias_in   = 16'h0000;
        act_mode  = 2'd1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid_rst_no_out_%0d", i), {31'd0, out_valid}, 32'd0);
        end
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send_neuron(16'h0100, 16'h0100, 16'h0000, 2'd1, 1'b0);
        get_result("mid_rst_clean", 16'h0800);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/neuron_mac_pipe.md
Name: neuron_mac_pipe

Overview:
Parametrised multi-lane successor to the single-lane serial neuron. It consumes LANES input/weight pairs per beat, accumulates the products in a two-stage pipeline and adds a fixed-point bias. It then applies a run-time selectable activation and presents the result on a ready/valid output with backpressure. It sits between the layer weight/activation streamer and the next layer's input buffer.

Parameters:
IN_WIDTH, 16, signed width of each data/weight/bias element (Q format, FRAC_BITS fractional bits)
OUT_WIDTH, 16, signed output width, same Q format as inputs
FRAC_BITS, 8, fractional bits of inputs, bias and output
LANES, 4, parallel pairs per beat
NUM_INPUTS, 784, inputs per neuron; must be a multiple of LANES (elaboration error otherwise)
ACC_WIDTH, 48, accumulator width; must be >= 2*IN_WIDTH+clog2(NUM_INPUTS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
data_in  in  LANES*IN_WIDTH  packed data lanes, lane 0 in LSBs
weight_in  in  LANES*IN_WIDTH  packed weight lanes, lane 0 in LSBs
bias_in  in  IN_WIDTH  bias; sampled on last-beat accept
act_mode  in  2  0=identity, 1=ReLU, 2=leaky ReLU (neg >>>3), 3=identity; sampled on last-beat accept
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
data_out  out  OUT_WIDTH  activated result
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accepts result

Behaviour:
- Reset: all outputs 0 except in_ready=1; accumulator, beat counter and pipeline valids cleared; state ACCUM. Reset mid-neuron discards the partial sum; the next accepted beat is beat 0.
- States: ACCUM (in_ready=1), DRAIN (in_ready=0), FINAL (in_ready=0), OUT (in_ready=0, out_valid=1).
- ACCUM: each accepted beat registers the LANES signed products (stage 1). The next cycle sums them in an adder tree, sign-extends to ACC_WIDTH and adds into the accumulator (stage 2). beat_cnt counts 0..NUM_INPUTS/LANES-1.
- Accepting the beat with beat_cnt = last moves to DRAIN, latches bias_in and act_mode, and resets beat_cnt to 0.
- DRAIN: one cycle, so that the last stage-1 products reach the accumulator -> FINAL.
- FINAL:
  - sum = acc + (sign-extended bias << FRAC_BITS).
  - res = sum >>> FRAC_BITS (arithmetic).
  - Apply activation, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - ReLU: res<0 -> 0.
  - Leaky: res<0 -> res>>>3, rounding toward -inf.
  - Register data_out, set out_valid, clear acc -> OUT.
- OUT: data_out and out_valid hold stable while out_ready=0. On out_valid && out_ready, out_valid drops next cycle and the block returns to ACCUM (in_ready=1 the same next cycle).
- Latency: out_valid first high 3 cycles after the clock edge accepting the last beat (zero-wait out_ready). Throughput: one neuron per NUM_INPUTS/LANES+3 cycles with zero-wait out_ready.
- in_valid low in ACCUM: no accumulation and no counter change; gaps are allowed anywhere.
- data_in, weight_in and in_valid are ignored while in_ready=0.

Optional Feature:
NEURON_SAT_FLAG_EN
- Defined: adds output sat_flag (1 bit), registered alongside data_out. It is high when the result was clamped at either rail (before clamping, ReLU zeroing does not count) and holds with data_out. It resets to 0.
- Undefined: the port is absent and there is no extra logic.

Decomposition:
- Shared package nn_pkg: act_mode encodings (ACT_IDENT, ACT_RELU, ACT_LEAKY), state enum, and a saturate/clamp function.
- One sub-module, neuron_act_sat: combinational shift, activation and clamp, instantiated in FINAL.
- The adder tree stays inline.

Test Plan:
(Common setup: LANES=4, NUM_INPUTS=8, FRAC_BITS=8, all widths 16, out_ready=1 unless noted.)
- All data 0x0100, weights 0x0100, bias 0, mode 1 -> data_out=0x0800 on the 3rd cycle after the 2nd beat's accept edge.
- Weights 0xFF00, bias 0x0080: mode 0 -> 0xF880; mode 1 -> 0x0000; mode 2 -> 0xFF10.
- Data=weights=0x7FFF, mode 0 -> 0x7FFF with sat_flag=1. Data 0x7FFF, weights 0x8000, mode 0 -> 0x8000 with sat_flag=1.
- Backpressure: out_ready low 5 cycles after out_valid -> data_out and out_valid stable, in_ready=0, next neuron's beats not consumed. Raise out_ready -> next neuron's result correct.
- in_valid toggled 1/0 every cycle -> same results as the contiguous stream.
- rst asserted for 1 cycle after beat 0 of a neuron -> no output. The following full 2-beat neuron yields the clean expected 0x0800.
